// File: rtl/dds_pkg.sv
// Shared types and helpers for the DDS sweep controller.
package dds_pkg;

  localparam int unsigned FW_W_DEF = 32;
  localparam int unsigned PW_W_DEF = 12;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StGap
  } dds_state_e;

  // Zero-valued lengths and counts behave as one.
  function automatic logic [31:0] clamp_min1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/dds_down_timer.sv
// Loadable down-counter; expire_o is high during the final counted cycle.
module dds_down_timer #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         expire_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= (cnt_d == W'(1));
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Stepped-frequency burst sequencer driving the DDS frequency/phase words and enable.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned FW_W  = FW_W_DEF,
  parameter int unsigned PW_W  = PW_W_DEF,
  parameter int unsigned GAP_W = 24
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Start,
  input  logic            Abort,
  input  logic [FW_W-1:0] F_Start,
  input  logic [FW_W-1:0] F_Step,
  input  logic [15:0]     Step_Len,
  input  logic [15:0]     Step_Num,
  input  logic [7:0]      Burst_Num,
  input  logic [GAP_W-1:0] Gap_Len,
  input  logic [PW_W-1:0] P_Offset,
  output logic            EN,
  output logic [FW_W-1:0] Fword,
  output logic [PW_W-1:0] Pword,
  output logic            Busy,
  output logic            Done
);

  dds_state_e       state_q;
  logic             en_q, busy_q, done_q;
  logic [FW_W-1:0]  fword_q, f_start_q, f_step_q;
  logic [PW_W-1:0]  pword_q;
  logic [15:0]      step_len_q, step_num_q, step_cnt_q;
  logic [7:0]       burst_cnt_q;
  logic [GAP_W-1:0] gap_len_q;

  logic [15:0]      step_len_c, step_num_c, step_load_val;
  logic [7:0]       burst_num_c;
  logic [GAP_W-1:0] gap_len_c;
  logic             step_exp, gap_exp;
  logic             accept, step_end, gap_end, more_steps, more_bursts;
  logic             step_load, gap_load;

  assign step_len_c  = 16'(clamp_min1(32'(Step_Len)));
  assign step_num_c  = 16'(clamp_min1(32'(Step_Num)));
  assign burst_num_c = 8'(clamp_min1(32'(Burst_Num)));
  assign gap_len_c   = GAP_W'(clamp_min1(32'(Gap_Len)));

  assign accept      = (state_q == StIdle) && Start && !Abort;
  assign step_end    = (state_q == StRun) && step_exp && !Abort;
  assign gap_end     = (state_q == StGap) && gap_exp && !Abort;
  assign more_steps  = step_cnt_q > 16'd1;
  assign more_bursts = burst_cnt_q > 8'd1;

  // On accept the shadows are not yet valid, so load straight from the inputs.
  assign step_load     = accept || (step_end && more_steps) || gap_end;
  assign step_load_val = accept ? step_len_c : step_len_q;
  assign gap_load      = step_end && !more_steps && more_bursts;

  dds_down_timer #(
    .W (16)
  ) u_step_timer (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .load_i     (step_load),
    .en_i       (state_q == StRun),
    .load_val_i (step_load_val),
    .expire_o   (step_exp)
  );

  dds_down_timer #(
    .W (GAP_W)
  ) u_gap_timer (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .load_i     (gap_load),
    .en_i       (state_q == StGap),
    .load_val_i (gap_len_q),
    .expire_o   (gap_exp)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StIdle;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fword_q     <= '0;
      pword_q     <= '0;
      f_start_q   <= '0;
      f_step_q    <= '0;
      step_len_q  <= '0;
      step_num_q  <= '0;
      step_cnt_q  <= '0;
      burst_cnt_q <= '0;
      gap_len_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (Abort) begin
        state_q <= StIdle;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (Start) begin
              f_start_q   <= F_Start;
              f_step_q    <= F_Step;
              step_len_q  <= step_len_c;
              step_num_q  <= step_num_c;
              gap_len_q   <= gap_len_c;
              pword_q     <= P_Offset;
              fword_q     <= F_Start;
              step_cnt_q  <= step_num_c;
              burst_cnt_q <= burst_num_c;
              state_q     <= StRun;
              en_q        <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
          StRun: begin
            if (step_exp) begin
              if (more_steps) begin
                fword_q    <= fword_q + f_step_q;
                step_cnt_q <= step_cnt_q - 16'd1;
              end else if (more_bursts) begin
                burst_cnt_q <= burst_cnt_q - 8'd1;
                fword_q     <= f_start_q;
                state_q     <= StGap;
                en_q        <= 1'b0;
              end else begin
                state_q <= StIdle;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          StGap: begin
            if (gap_exp) begin
              step_cnt_q <= step_num_q;
              state_q    <= StRun;
              en_q       <= 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign EN    = en_q;
  assign Fword = fword_q;
  assign Pword = pword_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: sweeps, bursts with gaps, zero config, abort and reset.
module tb_dds_sweep_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [31:0] F_Start = '0;
  logic [31:0] F_Step = '0;
  logic [15:0] Step_Len = '0;
  logic [15:0] Step_Num = '0;
  logic [7:0]  Burst_Num = '0;
  logic [23:0] Gap_Len = '0;
  logic [11:0] P_Offset = '0;
  logic        EN, Busy, Done;
  logic [31:0] Fword;
  logic [11:0] Pword;

  int checks = 0;
  int failures = 0;

  dds_sweep_ctrl #(
    .FW_W  (32),
    .PW_W  (12),
    .GAP_W (24)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Abort     (Abort),
    .F_Start   (F_Start),
    .F_Step    (F_Step),
    .Step_Len  (Step_Len),
    .Step_Num  (Step_Num),
    .Burst_Num (Burst_Num),
    .Gap_Len   (Gap_Len),
    .P_Offset  (P_Offset),
    .EN        (EN),
    .Fword     (Fword),
    .Pword     (Pword),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the sample point of the first RUN cycle.
  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(output int en_cycles, output bit got);
    en_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (Done) begin
        got = 1'b1;
        break;
      end
      if (EN) en_cycles++;
      tick();
    end
  endtask

  initial begin
    int en_cnt;
    bit got;
    int done_cnt;
    logic [31:0] dvals [3];
    dvals[0] = 32'h0000_0010;
    dvals[1] = 32'h0000_0000;
    dvals[2] = 32'hFFFF_FFF0;

    // Reset values
    #3;
    chk1("rst_en", EN, 1'b0);
    chk("rst_fword", Fword, 32'h0);
    chk("rst_pword", 32'(Pword), 32'h0);
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_done", Done, 1'b0);
    #4 Rst_n = 1'b1;
    tick();

    // Single-burst up-sweep
    F_Start = 32'h0100_0000; F_Step = 32'h0010_0000;
    Step_Len = 16'd4; Step_Num = 16'd3; Burst_Num = 8'd1; Gap_Len = 24'd0;
    P_Offset = 12'hABC;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      chk1("up_en", EN, 1'b1);
      chk1("up_busy", Busy, 1'b1);
      chk("up_fword", Fword, 32'h0100_0000 + 32'h0010_0000 * 32'(i / 4));
      tick();
    end
    chk("up_pword", 32'(Pword), 32'hABC);
    chk1("up_done", Done, 1'b1);
    chk1("up_en_end", EN, 1'b0);
    chk1("up_busy_end", Busy, 1'b0);
    tick();
    chk1("up_done_pulse", Done, 1'b0);

    // Multi-burst with gaps
    F_Start = 32'h0000_1000; F_Step = 32'h0000_0010;
    Step_Len = 16'd2; Step_Num = 16'd2; Burst_Num = 8'd3; Gap_Len = 24'd5;
    pulse_start();
    done_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) begin
        chk1("mb_en", EN, 1'b1);
        chk1("mb_busy", Busy, 1'b1);
        chk("mb_fword", Fword, 32'h0000_1000 + 32'h10 * 32'(i / 2));
        if (Done) done_cnt++;
        tick();
      end
      if (b < 2) begin
        for (int i = 0; i < 5; i++) begin
          chk1("mb_gap_en", EN, 1'b0);
          chk1("mb_gap_busy", Busy, 1'b1);
          chk("mb_gap_fword", Fword, 32'h0000_1000);
          if (Done) done_cnt++;
          tick();
        end
      end
    end
    chk1("mb_done", Done, 1'b1);
    if (Done) done_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Done) done_cnt++;
    end
    chk("mb_done_count", 32'(done_cnt), 32'd1);

    // Down-sweep with wrap
    F_Start = 32'h0000_0010; F_Step = 32'hFFFF_FFF0;
    Step_Len = 16'd2; Step_Num = 16'd3; Burst_Num = 8'd1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      chk("dn_fword", Fword, dvals[i / 2]);
      tick();
    end
    chk1("dn_done", Done, 1'b1);
    tick();

    // Zero config: single cycle, then with two bursts a one-cycle gap
    F_Start = 32'h0000_0055; F_Step = 32'h1;
    Step_Len = 16'd0; Step_Num = 16'd0; Burst_Num = 8'd0; Gap_Len = 24'd0;
    pulse_start();
    chk1("z_en", EN, 1'b1);
    chk("z_fword", Fword, 32'h55);
    tick();
    chk1("z_en_off", EN, 1'b0);
    chk1("z_done", Done, 1'b1);
    tick();
    Burst_Num = 8'd2;
    pulse_start();
    chk1("zg_en1", EN, 1'b1);
    tick();
    chk1("zg_gap_en", EN, 1'b0);
    chk1("zg_gap_busy", Busy, 1'b1);
    tick();
    chk1("zg_en2", EN, 1'b1);
    tick();
    chk1("zg_done", Done, 1'b1);
    tick();

    // Abort on the third RUN cycle
    F_Start = 32'h0200_0000; F_Step = 32'h100;
    Step_Len = 16'd4; Step_Num = 16'd3; Burst_Num = 8'd1;
    pulse_start();
    tick();
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk1("ab_en", EN, 1'b0);
    chk1("ab_busy", Busy, 1'b0);
    chk1("ab_done", Done, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Done) done_cnt++;
    end
    chk("ab_no_done", 32'(done_cnt), 32'd0);

    // Start together with Abort in IDLE
    Start = 1'b1; Abort = 1'b1;
    tick();
    Start = 1'b0; Abort = 1'b0;
    chk1("sa_busy", Busy, 1'b0);
    chk1("sa_en", EN, 1'b0);
    tick();

    // Start while Busy is ignored; Start in the Done cycle is accepted
    Step_Len = 16'd2; Step_Num = 16'd2; Burst_Num = 8'd1;
    pulse_start();
    Start = 1'b1; Step_Len = 16'd9; Step_Num = 16'd9; Burst_Num = 8'd5;
    tick();
    Start = 1'b0;
    wait_done(en_cnt, got);
    chk1("sb_done", got, 1'b1);
    chk("sb_en_cycles", 32'(en_cnt), 32'd3);
    Step_Len = 16'd2; Step_Num = 16'd2; Burst_Num = 8'd1;
    pulse_start();
    chk1("sd_en", EN, 1'b1);
    chk1("sd_busy", Busy, 1'b1);
    wait_done(en_cnt, got);
    chk1("sd_done", got, 1'b1);
    chk("sd_en_cycles", 32'(en_cnt), 32'd4);
    tick();

    // Asynchronous reset mid-burst
    Step_Len = 16'd4; Step_Num = 16'd3; Burst_Num = 8'd1; P_Offset = 12'h123;
    pulse_start();
    tick();
    Rst_n = 1'b0;
    #2;
    chk1("ar_en", EN, 1'b0);
    chk("ar_fword", Fword, 32'h0);
    chk("ar_pword", 32'(Pword), 32'h0);
    chk1("ar_busy", Busy, 1'b0);
    chk1("ar_done", Done, 1'b0);
    Rst_n = 1'b1;
    tick();
    pulse_start();
    chk("ar_fword_restart", Fword, 32'h0200_0000);
    wait_done(en_cnt, got);
    chk1("ar_after_done", got, 1'b1);
    chk("ar_after_en_cycles", 32'(en_cnt), 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
